adpll_core: RTL and testbench

//  All-digital PLL clocked by fpga_clk_i. Locks the internally generated gen_clk_o to an

---
 rtl/adpll_pkg.sv | 46 ++++
 rtl/adpll_phase_det.sv | 102 ++++++++++
 rtl/adpll_core.sv | 80 ++++++++
 tb/tb_adpll_core.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adpll_pkg
//  Brief    : Shared widths, loop constants, PD state type and saturation helpers.
//  Revision : 1.0
// ============================================================================
package adpll_pkg;

    localparam int ERR_W    = 8;
    localparam int CC_W     = 9;
    localparam int ACC_W    = 16;
    localparam int INT_W    = 16;
    localparam int CNT_W    = 7;

    localparam int BASE_INC = 1311;
    localparam int KP_SHIFT = 0;
    localparam int KI_SHIFT = 4;
    localparam int ERR_MAX  = 127;
    localparam int CC_MAX   = 255;

    localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        PD_IDLE     = 2'd0,
        PD_REF_LEAD = 2'd1,
        PD_GEN_LEAD = 2'd2
    } pd_state_t;

    // Counter stops at all-ones, which equals ERR_MAX for a 7-bit count.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    function automatic logic signed [CC_W-1:0] sat_cc(input logic signed [31:0] v);
        if (v > CC_MAX)
            return CC_W'(CC_MAX);
        else if (v < -CC_MAX)
            return CC_W'(-CC_MAX);
        else
            return v[CC_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/adpll_phase_det.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adpll_phase_det
//  Brief    : Ref synchroniser, edge detection and saturating TDC phase detector.
//  Revision : 1.0
// ============================================================================
module adpll_phase_det
    import adpll_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    ref_clk_i,
    input  logic                    gen_clk_i,
    output logic signed [ERR_W-1:0] error_o,
    output logic                    err_valid_o
);

    // [1:0] is the two-flop synchroniser, [2] is the history bit for edge detection.
    logic [2:0]              ref_sync_q;
    logic                    gen_prev_q;
    pd_state_t               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ERR_W-1:0] error_q, error_d;
    logic                    valid_q, valid_d;
    logic                    ref_edge, gen_edge;

    assign ref_edge = ref_sync_q[1] & ~ref_sync_q[2];
    assign gen_edge = gen_clk_i & ~gen_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        valid_d = 1'b0;
        case (state_q)
            PD_IDLE: begin
                if (ref_edge && gen_edge) begin
                    error_d = '0;
                    valid_d = 1'b1;
                end else if (ref_edge) begin
                    state_d = PD_REF_LEAD;
                    cnt_d   = CNT_W'(1);
                end else if (gen_edge) begin
                    state_d = PD_GEN_LEAD;
                    cnt_d   = CNT_W'(1);
                end
            end
            PD_REF_LEAD: begin
                if (gen_edge) begin
                    error_d = $signed({1'b0, cnt_q});
                    valid_d = 1'b1;
                    state_d = PD_IDLE;
                    cnt_d   = '0;
                end else if (ref_edge) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            PD_GEN_LEAD: begin
                if (ref_edge) begin
                    error_d = -$signed({1'b0, cnt_q});
                    valid_d = 1'b1;
                    state_d = PD_IDLE;
                    cnt_d   = '0;
                end else if (gen_edge) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            default: begin
                state_d = PD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ref_sync_q <= '0;
            gen_prev_q <= 1'b0;
            state_q    <= PD_IDLE;
            cnt_q      <= '0;
            error_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            ref_sync_q <= {ref_sync_q[1:0], ref_clk_i};
            gen_prev_q <= gen_clk_i;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
            valid_q    <= valid_d;
        end
    end

    assign error_o     = error_q;
    assign err_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/adpll_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adpll_core
//  Brief    : All-digital PLL: phase detector, saturating PI filter, accumulator DCO.
//  Revision : 1.0
// ============================================================================
module adpll_core
    import adpll_pkg::*;
(
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    ref_clk_i,
    input  logic                    enable_i,
    output logic                    gen_clk_o,
    output logic signed [ERR_W-1:0] error_o,
    output logic signed [CC_W-1:0]  dco_cc_o
);

    logic signed [ERR_W-1:0] pd_error;
    logic                    pd_valid;
    logic signed [INT_W-1:0] integ_q, integ_d, integ_new;
    logic [INT_W:0]          integ_sum;
    logic signed [31:0]      cc_sum;
    logic signed [CC_W-1:0]  cc_q, cc_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    gen_q, gen_d;

    adpll_phase_det u_phase_det (
        .clk_i       (fpga_clk_i),
        .reset_i     (reset_i),
        .ref_clk_i   (ref_clk_i),
        .gen_clk_i   (gen_q),
        .error_o     (pd_error),
        .err_valid_o (pd_valid)
    );

    always_comb begin
        integ_sum = {integ_q[INT_W-1], integ_q} + (INT_W+1)'(pd_error);
        if (integ_sum[INT_W] != integ_sum[INT_W-1])
            integ_new = integ_sum[INT_W] ? INT_MIN : INT_MAX;
        else
            integ_new = integ_sum[INT_W-1:0];
        cc_sum = 32'(pd_error >>> KP_SHIFT) + 32'(integ_new >>> KI_SHIFT);

        integ_d = integ_q;
        cc_d    = cc_q;
        if (!enable_i) begin
            integ_d = '0;
            cc_d    = '0;
        end else if (pd_valid) begin
            integ_d = integ_new;
            cc_d    = sat_cc(cc_sum);
        end

        // |cc| <= 255 < BASE_INC, so the step is always positive.
        acc_d = acc_q + ACC_W'(BASE_INC) + ACC_W'(cc_q);
        gen_d = acc_q[ACC_W-1];
    end

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            integ_q <= '0;
            cc_q    <= '0;
            acc_q   <= '0;
            gen_q   <= 1'b0;
        end else begin
            integ_q <= integ_d;
            cc_q    <= cc_d;
            acc_q   <= acc_d;
            gen_q   <= gen_d;
        end
    end

    assign gen_clk_o = gen_q;
    assign error_o   = pd_error;
    assign dco_cc_o  = cc_q;

endmodule
`default_nettype wire

// File: tb/tb_adpll_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_adpll_core
//  Brief    : Self-checking bench for adpll_core plus a standalone phase detector.
//  Revision : 1.0
// ============================================================================
module tb_adpll_core;

    logic              clk = 1'b0;
    logic              rst;
    logic              ref_top;
    logic              en;
    logic              gen_o;
    logic signed [7:0] err_o;
    logic signed [8:0] cc_o;

    logic              pd_rst;
    logic              pd_ref;
    logic              pd_gen;
    logic signed [7:0] pd_err;
    logic              pd_valid;

    bit ref_run = 1'b0;
    int errors  = 0;
    int checks  = 0;

    adpll_core dut (
        .fpga_clk_i (clk),
        .reset_i    (rst),
        .ref_clk_i  (ref_top),
        .enable_i   (en),
        .gen_clk_o  (gen_o),
        .error_o    (err_o),
        .dco_cc_o   (cc_o)
    );

    adpll_phase_det u_pd (
        .clk_i       (clk),
        .reset_i     (pd_rst),
        .ref_clk_i   (pd_ref),
        .gen_clk_i   (pd_gen),
        .error_o     (pd_err),
        .err_valid_o (pd_valid)
    );

    always #2 clk = ~clk;

    // 198 ns reference, asynchronous to the 4 ns system clock.
    initial begin
        ref_top = 1'b0;
        forever begin
            wait (ref_run);
            ref_top = 1'b1;
            #99;
            ref_top = 1'b0;
            #99;
        end
    end

    // Expected TDC reading for a ref-minus-gen offset of d cycles.
    function automatic int pd_model(input int d);
        if (d > 127)  return 127;
        if (d < -127) return -127;
        return d;
    endfunction

    task automatic measure_period(output int period);
        logic prev;
        int   n;
        bit   seen;
        period = -1;
        seen   = 1'b0;
        n      = 0;
        @(negedge clk);
        prev = gen_o;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (seen) n++;
            if (gen_o && !prev) begin
                if (seen) begin
                    period = n;
                    break;
                end
                seen = 1'b1;
                n    = 0;
            end
            prev = gen_o;
        end
    endtask

    // Rises (2-cycle pulses) at the given negedge indices; returns just before posedge 'last'.
    task automatic pd_drive(input int r0, input int r1, input int g0, input int g1, input int last);
        for (int c = 0; c < last; c++) begin
            @(negedge clk);
            if (c == r0 || c == r1)          pd_ref = 1'b1;
            else if (c == r0+2 || c == r1+2) pd_ref = 1'b0;
            if (c == g0 || c == g1)          pd_gen = 1'b1;
            else if (c == g0+2 || c == g1+2) pd_gen = 1'b0;
        end
    endtask

    task automatic pd_idle();
        @(negedge clk);
        pd_ref = 1'b0;
        pd_gen = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pd_trial(input int d, input string name);
        int r, g, exp_v;
        r     = 2 + ((d < 0) ? -d : 0);
        g     = 4 + ((d > 0) ? d : 0);
        exp_v = pd_model(d);
        pd_drive(r, -100, g, -100, 5 + ((d < 0) ? -d : d));
        @(posedge clk); #1;
        checks++;
        if (pd_err !== 8'(exp_v)) begin
            errors++;
            $display("FAIL %s d=%0d: error=%0d expected %0d", name, d, pd_err, exp_v);
        end
        checks++;
        if (pd_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid d=%0d: err_valid=%b expected 1", name, d, pd_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (pd_valid !== 1'b0 || pd_err !== 8'(exp_v)) begin
            errors++;
            $display("FAIL %s_hold d=%0d: err_valid=%b error=%0d expected 0/%0d", name, d, pd_valid, pd_err, exp_v);
        end
        pd_idle();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        pd_rst = 1'b1;
        en     = 1'b1;
        pd_ref = 1'b0;
        pd_gen = 1'b0;
        #100;
        checks++;
        if (gen_o !== 1'b0) begin errors++; $display("FAIL reset_gen: got %b expected 0", gen_o); end
        checks++;
        if (err_o !== 8'sd0) begin errors++; $display("FAIL reset_error: got %0d expected 0", err_o); end
        checks++;
        if (cc_o !== 9'sd0) begin errors++; $display("FAIL reset_cc: got %0d expected 0", cc_o); end
    endtask

    task automatic test_free_run();
        int p;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            measure_period(p);
            checks++;
            if (p < 49 || p > 51) begin
                errors++;
                $display("FAIL free_run_period: got %0d expected 50+/-1", p);
            end
        end
        checks++;
        if (err_o !== 8'sd0 || cc_o !== 9'sd0) begin
            errors++;
            $display("FAIL free_run_idle: error=%0d cc=%0d expected 0/0", err_o, cc_o);
        end
    endtask

    task automatic test_pd_reset();
        checks++;
        if (pd_err !== 8'sd0 || pd_valid !== 1'b0) begin
            errors++;
            $display("FAIL pd_reset: error=%0d valid=%b expected 0/0", pd_err, pd_valid);
        end
        @(negedge clk);
        pd_rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_pd_directed();
        int ds[9] = '{0, 20, -20, 1, -1, 127, 128, 150, -150};
        foreach (ds[i]) pd_trial(ds[i], "pd_directed");
    endtask

    task automatic test_pd_restart();
        // Second ref edge restarts the count; the first one is forgotten.
        pd_drive(2, 12, 29, -100, 30);
        @(posedge clk); #1;
        checks++;
        if (pd_err !== 8'sd15) begin
            errors++;
            $display("FAIL pd_ref_restart: error=%0d expected 15", pd_err);
        end
        pd_idle();
        pd_drive(19, -100, 2, 12, 22);
        @(posedge clk); #1;
        checks++;
        if (pd_err !== -8'sd9) begin
            errors++;
            $display("FAIL pd_gen_restart: error=%0d expected -9", pd_err);
        end
        pd_idle();
    endtask

    task automatic test_pd_random();
        for (int i = 0; i < 30; i++) begin
            int d;
            d = int'($urandom_range(0, 360)) - 180;
            pd_trial(d, "pd_random");
        end
    endtask

    task automatic test_lock();
        int max_abs, cc_min, cc_max, e;
        ref_run = 1'b1;
        repeat (20000) @(negedge clk);
        max_abs = 0;
        cc_min  = 1000;
        cc_max  = -1000;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            e = int'(err_o);
            if (e < 0) e = -e;
            if (e > max_abs) max_abs = e;
            if (int'(cc_o) < cc_min) cc_min = int'(cc_o);
            if (int'(cc_o) > cc_max) cc_max = int'(cc_o);
        end
        checks++;
        if (max_abs > 2) begin
            errors++;
            $display("FAIL lock_error: max |error|=%0d expected <=2", max_abs);
        end
        checks++;
        if (cc_min < 10 || cc_max > 16) begin
            errors++;
            $display("FAIL lock_cc: range %0d..%0d expected within 13+/-3", cc_min, cc_max);
        end
    endtask

    task automatic test_disable();
        int p;
        logic signed [7:0] first;
        bit changed;
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cc_o !== 9'sd0) begin
            errors++;
            $display("FAIL disable_cc: got %0d expected 0", cc_o);
        end
        measure_period(p);
        measure_period(p);
        checks++;
        if (p < 49 || p > 51) begin
            errors++;
            $display("FAIL disable_period: got %0d expected 50+/-1", p);
        end
        first   = err_o;
        changed = 1'b0;
        for (int i = 0; i < 3000 && !changed; i++) begin
            @(negedge clk);
            if (err_o !== first) changed = 1'b1;
        end
        checks++;
        if (!changed || cc_o !== 9'sd0) begin
            errors++;
            $display("FAIL disable_pd_running: error_changed=%b cc=%0d expected 1/0", changed, cc_o);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        repeat (300) @(negedge clk);
        #1;
        rst = 1'b1;
        #0.5;
        checks++;
        if (gen_o !== 1'b0 || err_o !== 8'sd0 || cc_o !== 9'sd0) begin
            errors++;
            $display("FAIL async_reset_top: gen=%b error=%0d cc=%0d expected 0/0/0", gen_o, err_o, cc_o);
        end
        ref_run = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b0;

        // Standalone PD: abort a REF_LEAD measurement, then check a clean restart.
        pd_trial(33, "pd_pre_reset");
        pd_drive(2, -100, -100, -100, 20);
        #1;
        pd_rst = 1'b1;
        #0.5;
        checks++;
        if (pd_err !== 8'sd0 || pd_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_pd: error=%0d valid=%b expected 0/0", pd_err, pd_valid);
        end
        @(negedge clk);
        pd_rst = 1'b0;
        pd_ref = 1'b0;
        repeat (4) @(negedge clk);
        // Gen first now: a surviving REF_LEAD would report a positive value instead.
        pd_trial(-12, "pd_after_reset");
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_pd_reset();
        test_pd_directed();
        test_pd_restart();
        test_pd_random();
        test_lock();
        test_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
